// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32 core.
// Walks each instruction through fetch/decode/execute/writeback.
// Datapath selects are decoded from the current state. The fetch and
// memory-wait states also look at mem_ready.
module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               funct7_5,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               ir_write,
   output logic               address_source,
   output logic               memory_write,
   output logic               register_write,
   output logic [1:0]         alu_source_a,
   output logic [1:0]         alu_source_b,
   output logic [2:0]         alu_control,
   output logic [1:0]         result_source,
   output logic [1:0]         immediate_source,
   output logic               retire,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_LUI_WB    = 4'd9,
      S_ILLEGAL   = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   state_t cur, nxt;

   // Raw enables before they are forced low during reset.
   logic pc_write_raw, ir_write_raw, memory_write_raw, register_write_raw, retire_raw;

   // funct3 to ALU operation. Only R-type may turn add into sub.
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7_5,
                                             input logic is_r);
      logic [2:0] op;
      case (f3)
         3'b000:  op = (is_r && f7_5) ? 3'b001 : 3'b000;
         3'b010:  op = 3'b101;
         3'b100:  op = 3'b100;
         3'b110:  op = 3'b011;
         3'b111:  op = 3'b010;
         default: op = 3'b000;
      endcase
      return op;
   endfunction

   // State register. Reset always returns to FETCH.
   always_ff @(posedge clk) begin
      if (reset) cur <= S_FETCH;
      else       cur <= nxt;
   end

   // Sticky illegal flag. Only reset clears it.
   always_ff @(posedge clk) begin
      if (reset)                 illegal <= 1'b0;
      else if (cur == S_ILLEGAL) illegal <= 1'b1;
   end

   // Next-state logic and per-state datapath controls.
   always_comb begin
      nxt                = cur;
      pc_write_raw       = 1'b0;
      ir_write_raw       = 1'b0;
      memory_write_raw   = 1'b0;
      register_write_raw = 1'b0;
      retire_raw         = 1'b0;
      address_source     = 1'b0;
      alu_source_a       = 2'b00;
      alu_source_b       = 2'b00;
      alu_control        = 3'b000;
      result_source      = 2'b00;
      immediate_source   = 2'b11;
      case (cur)
         S_FETCH: begin
            alu_source_b = 2'b10;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               nxt          = S_DECODE;
            end
         end
         S_DECODE: begin
            // Precompute the branch target (old PC + imm) even though it is unused here.
            alu_source_a     = 2'b01;
            alu_source_b     = 2'b01;
            immediate_source = 2'b00;
            case (opcode)
               OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
               OP_R:              nxt = S_EXEC_R;
               OP_I:              nxt = S_EXEC_I;
               OP_LUI:            nxt = S_LUI_WB;
               default:           nxt = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR: begin
            alu_source_a     = 2'b10;
            alu_source_b     = 2'b01;
            immediate_source = (opcode == OP_STORE) ? 2'b01 : 2'b00;
            nxt              = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            address_source = 1'b1;
            if (mem_ready) nxt = S_MEM_WB;
         end
         S_MEM_WB: begin
            result_source      = 2'b01;
            register_write_raw = 1'b1;
            retire_raw         = 1'b1;
            nxt                = S_FETCH;
         end
         S_MEM_WRITE: begin
            address_source   = 1'b1;
            memory_write_raw = 1'b1;
            if (mem_ready) begin
               retire_raw = 1'b1;
               nxt        = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_source_a = 2'b10;
            alu_source_b = 2'b00;
            alu_control  = alu_decode(funct3, funct7_5, 1'b1);
            nxt          = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_source_a     = 2'b10;
            alu_source_b     = 2'b01;
            immediate_source = 2'b00;
            alu_control      = alu_decode(funct3, funct7_5, 1'b0);
            nxt              = S_ALU_WB;
         end
         S_ALU_WB: begin
            result_source      = 2'b00;
            register_write_raw = 1'b1;
            retire_raw         = 1'b1;
            nxt                = S_FETCH;
         end
         S_LUI_WB: begin
            immediate_source   = 2'b10;
            result_source      = 2'b11;
            register_write_raw = 1'b1;
            retire_raw         = 1'b1;
            nxt                = S_FETCH;
         end
         S_ILLEGAL: nxt = S_ILLEGAL;
         default:   nxt = S_ILLEGAL;
      endcase
   end

   // A reset cycle must never write the PC, IR, memory or register file.
   assign pc_write       = pc_write_raw       & ~reset;
   assign ir_write       = ir_write_raw       & ~reset;
   assign memory_write   = memory_write_raw   & ~reset;
   assign register_write = register_write_raw & ~reset;
   assign retire         = retire_raw         & ~reset;
   assign state          = STATE_W'(cur);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Each driven cycle pushes its expected state and controls into a queue.
// A checker on the falling edge pops each entry and compares it with the DUT.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        funct7_5 = 1'b0;
   logic        mem_ready = 1'b1;
   logic        pc_write, ir_write, address_source, memory_write, register_write;
   logic [1:0]  alu_source_a, alu_source_b, result_source, immediate_source;
   logic [2:0]  alu_control;
   logic        retire, illegal;
   logic [3:0]  state;

   multicycle_control_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .address_source(address_source), .memory_write(memory_write),
      .register_write(register_write), .alu_source_a(alu_source_a),
      .alu_source_b(alu_source_b), .alu_control(alu_control),
      .result_source(result_source), .immediate_source(immediate_source),
      .retire(retire), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, irw, asrc, mw, rw;
      logic [1:0] sa, sb;
      logic [2:0] alu;
      logic [1:0] rs, imm;
      logic       ret;
   } ctl_t;

   typedef struct {
      logic [3:0] st;
      ctl_t       ctl;
      logic       ill;
      logic       ill_chk;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      int          n;
      logic [11:0] mrdy;   // mem_ready for cycle k is bit k
      logic [47:0] seq;    // state for cycle k is seq[4k+:4]
      logic [2:0]  alu;
      logic [1:0]  mimm;
   } vec_t;

   exp_t q[$];
   int   passed = 0;
   int   total  = 0;
   vec_t vt[11];

   // Expected controls for each state, written directly from the state table.
   function automatic ctl_t exp_ctl(input logic [3:0] st, input logic mr,
                                    input logic [2:0] alu, input logic [1:0] mimm);
      ctl_t c;
      c = '0;
      c.imm = 2'b11;
      case (st)
         4'd0: begin c.sb = 2'b10; c.pcw = mr; c.irw = mr; end
         4'd1: begin c.sa = 2'b01; c.sb = 2'b01; c.imm = 2'b00; end
         4'd2: begin c.sa = 2'b10; c.sb = 2'b01; c.imm = mimm; end
         4'd3: c.asrc = 1'b1;
         4'd4: begin c.rs = 2'b01; c.rw = 1'b1; c.ret = 1'b1; end
         4'd5: begin c.asrc = 1'b1; c.mw = 1'b1; c.ret = mr; end
         4'd6: begin c.sa = 2'b10; c.sb = 2'b00; c.alu = alu; end
         4'd7: begin c.sa = 2'b10; c.sb = 2'b01; c.imm = 2'b00; c.alu = alu; end
         4'd8: begin c.rw = 1'b1; c.ret = 1'b1; end
         4'd9: begin c.imm = 2'b10; c.rs = 2'b11; c.rw = 1'b1; c.ret = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   // Drive one cycle of inputs and queue what the DUT must show for that cycle.
   task automatic cycle(input logic [31:0] instr, input logic mr, input logic rst,
                        input logic [3:0] st, input logic [2:0] alu, input logic [1:0] mimm,
                        input logic ill, input logic ill_chk);
      exp_t e;
      @(posedge clk);
      #1;
      opcode    = instr[6:0];
      funct3    = instr[14:12];
      funct7_5  = instr[30];
      mem_ready = mr;
      reset     = rst;
      e.st      = st;
      e.ctl     = exp_ctl(st, mr, alu, mimm);
      if (rst) begin
         e.ctl.pcw = 1'b0; e.ctl.irw = 1'b0; e.ctl.mw = 1'b0;
         e.ctl.rw  = 1'b0; e.ctl.ret = 1'b0;
      end
      e.ill     = ill;
      e.ill_chk = ill_chk;
      q.push_back(e);
   endtask

   task automatic run_vec(input vec_t v);
      for (int k = 0; k < v.n; k++)
         cycle(v.instr, v.mrdy[k], 1'b0, v.seq[k*4 +: 4], v.alu, v.mimm, 1'b0, 1'b1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
   endtask

   // Scoreboard checker: compare away from the rising edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         ctl_t a;
         e = q.pop_front();
         a = '{pc_write, ir_write, address_source, memory_write, register_write,
               alu_source_a, alu_source_b, alu_control, result_source, immediate_source, retire};
         chk("state", 32'(state), 32'(e.st));
         chk("controls", 32'(a), 32'(e.ctl));
         if (e.ill_chk) chk("illegal", 32'(illegal), 32'(e.ill));
      end
   end

   initial begin
      vt[0]  = '{"add",    32'h00208033, 4, 12'hFFF, 48'h8610,     3'b000, 2'b00};
      vt[1]  = '{"sub",    32'h40208033, 4, 12'hFFF, 48'h8610,     3'b001, 2'b00};
      vt[2]  = '{"addi_f7",32'h40100093, 4, 12'hFFF, 48'h8710,     3'b000, 2'b00};
      vt[3]  = '{"lw_wait",32'h00012083, 8, 12'hFC7, 48'h43333210, 3'b000, 2'b00};
      vt[4]  = '{"sw_wait",32'h00112023, 6, 12'hFE7, 48'h555210,   3'b000, 2'b01};
      vt[5]  = '{"lui",    32'h123450B7, 3, 12'hFFF, 48'h910,      3'b000, 2'b00};
      vt[6]  = '{"xor_fw", 32'h0020C033, 5, 12'hFFE, 48'h86100,    3'b100, 2'b00};
      vt[7]  = '{"slti",   32'h00512093, 4, 12'hFFF, 48'h8710,     3'b101, 2'b00};
      vt[8]  = '{"or",     32'h0020E033, 4, 12'hFFF, 48'h8610,     3'b011, 2'b00};
      vt[9]  = '{"andi",   32'h0FF17093, 4, 12'hFFF, 48'h8710,     3'b010, 2'b00};
      vt[10] = '{"sll_add",32'h00209033, 4, 12'hFFF, 48'h8610,     3'b000, 2'b00};

      // Two reset cycles: FETCH with every enable held low even though mem_ready=1.
      cycle(32'h0, 1'b1, 1'b1, 4'd0, 3'b000, 2'b00, 1'b0, 1'b1);
      cycle(32'h0, 1'b1, 1'b1, 4'd0, 3'b000, 2'b00, 1'b0, 1'b1);

      foreach (vt[i]) run_vec(vt[i]);

      // Unsupported opcode: ILLEGAL is terminal, raises the sticky flag and drives no enables.
      cycle(32'h00208063, 1'b1, 1'b0, 4'd0,  3'b000, 2'b00, 1'b0, 1'b1);
      cycle(32'h00208063, 1'b1, 1'b0, 4'd1,  3'b000, 2'b00, 1'b0, 1'b1);
      cycle(32'h00208063, 1'b1, 1'b0, 4'd15, 3'b000, 2'b00, 1'b0, 1'b0);
      cycle(32'h00208063, 1'b0, 1'b0, 4'd15, 3'b000, 2'b00, 1'b1, 1'b1);
      cycle(32'h00208063, 1'b1, 1'b0, 4'd15, 3'b000, 2'b00, 1'b1, 1'b1);
      cycle(32'h00208063, 1'b1, 1'b1, 4'd15, 3'b000, 2'b00, 1'b1, 1'b1);

      // Store interrupted by reset during its memory wait: no write in the reset cycle, then FETCH.
      cycle(32'h00112023, 1'b1, 1'b0, 4'd0, 3'b000, 2'b01, 1'b0, 1'b1);
      cycle(32'h00112023, 1'b1, 1'b0, 4'd1, 3'b000, 2'b01, 1'b0, 1'b1);
      cycle(32'h00112023, 1'b1, 1'b0, 4'd2, 3'b000, 2'b01, 1'b0, 1'b1);
      cycle(32'h00112023, 1'b0, 1'b0, 4'd5, 3'b000, 2'b01, 1'b0, 1'b1);
      cycle(32'h00112023, 1'b1, 1'b1, 4'd5, 3'b000, 2'b01, 1'b0, 1'b1);

      // A normal instruction afterwards starts cleanly from FETCH.
      run_vec(vt[0]);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
